frame_sequencer: RTL and testbench

- Per-frame controller for the single write port of the display/depth buffer.
- Sequences each frame through three phases: clear every location to a background pixel, grant the port to the depth comparator while rasterizers draw, then wait for drain and swap the double buffer in vblank.
- Sits between the rasterizer array, the depth comparator and the frame buffer; owns `raster_enable` and `buffer_select`.

---
 rtl/common.sv | 28 ++
 rtl/frame_sequencer_if.sv | 40 ++++
 rtl/raster_scan_counter.sv | 46 ++++
 rtl/frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_frame_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/common.sv
// Shared pixel types, coordinate width and frame sequencer state encoding.
package common;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned DEPTH_W = 8;
  localparam int unsigned COLOR_W = 24;

  typedef struct packed {
    logic [DEPTH_W-1:0] depth;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    pixel_t             pixel;
  } pixel_info_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRAW,
    DRAIN,
    SWAP_WAIT
  } frame_seq_state_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Control, depth-comparator and frame-buffer signals around the frame sequencer.
interface frame_sequencer_if;
  import common::*;

  logic               frame_start;
  logic               vblank;
  logic               raster_busy;
  logic               dc_all_complete;
  logic               dc_write_enable;
  logic [COORD_W-1:0] dc_address_x;
  logic [COORD_W-1:0] dc_address_y;
  pixel_t             dc_write_data;

  logic               raster_enable;
  logic               buffer_write_enable;
  logic [COORD_W-1:0] buffer_address_x;
  logic [COORD_W-1:0] buffer_address_y;
  pixel_t             buffer_write_data;
  logic               buffer_select;
  logic               frame_done;
  logic               busy;
  logic               overlap_error;

  modport slave (
    input  frame_start, vblank, raster_busy, dc_all_complete,
           dc_write_enable, dc_address_x, dc_address_y, dc_write_data,
    output raster_enable, buffer_write_enable, buffer_address_x,
           buffer_address_y, buffer_write_data, buffer_select,
           frame_done, busy, overlap_error
  );

  modport master (
    output frame_start, vblank, raster_busy, dc_all_complete,
           dc_write_enable, dc_address_x, dc_address_y, dc_write_data,
    input  raster_enable, buffer_write_enable, buffer_address_x,
           buffer_address_y, buffer_write_data, buffer_select,
           frame_done, busy, overlap_error
  );

endinterface

// File: rtl/raster_scan_counter.sv
// Raster-order x/y counter with a registered flag marking the final position.
module raster_scan_counter
  import common::*;
#(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(V_RES - 1);
  localparam logic               SINGLE = (H_RES == 1) && (V_RES == 1);

  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;

  always_comb begin
    x_next = x + COORD_W'(1);
    y_next = y;
    if (x == X_MAX) begin
      x_next = '0;
      y_next = (y == Y_MAX) ? '0 : y + COORD_W'(1);
    end
  end

  // last is precomputed so the consumer sees it alongside the final address
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      x    <= '0;
      y    <= '0;
      last <= SINGLE;
    end else if (enable) begin
      x    <= x_next;
      y    <= y_next;
      last <= (x_next == X_MAX) && (y_next == Y_MAX);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame owner of the buffer write port: clear, draw grant, drain, then vblank swap.
module frame_sequencer
  import common::*;
#(
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter pixel_t      CLEAR_PIXEL  = '0,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic               clock,
  input logic               reset,
  frame_sequencer_if.slave  bus
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  frame_seq_state_t   state;
  logic               pending;
  logic [DRAIN_W-1:0] drain_count;
  logic [DRAIN_W-1:0] drain_next;
  logic               clear_active;
  logic               pass_active;
  logic               raster_enable_r;
  logic               busy_r;
  logic               frame_done_r;
  logic               buffer_select_r;
  logic               overlap_error_r;

  logic               start_req;
  logic               swap_now;
  logic               scan_clear;
  logic               scan_enable;
  logic [COORD_W-1:0] scan_x;
  logic [COORD_W-1:0] scan_y;
  logic               scan_last;

  assign start_req   = bus.frame_start || pending;
  assign swap_now    = (state == SWAP_WAIT) && bus.vblank;
  assign scan_clear  = ((state == IDLE) && start_req) || (swap_now && start_req);
  assign scan_enable = (state == CLEAR);
  assign drain_next  = drain_count + DRAIN_W'(1);

  raster_scan_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_scan (
    .clock  (clock),
    .reset  (reset),
    .enable (scan_enable),
    .clear  (scan_clear),
    .x      (scan_x),
    .y      (scan_y),
    .last   (scan_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      pending         <= 1'b0;
      drain_count     <= '0;
      clear_active    <= 1'b0;
      pass_active     <= 1'b0;
      raster_enable_r <= 1'b0;
      busy_r          <= 1'b0;
      frame_done_r    <= 1'b0;
      buffer_select_r <= 1'b0;
      overlap_error_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      // comparator writes outside its grant are dropped and flagged
      if (bus.dc_write_enable && !pass_active) overlap_error_r <= 1'b1;
      if (bus.frame_start && (state != IDLE)) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start_req) begin
            state        <= CLEAR;
            pending      <= 1'b0;
            clear_active <= 1'b1;
            busy_r       <= 1'b1;
          end
        end
        CLEAR: begin
          if (scan_last) begin
            state           <= DRAW;
            clear_active    <= 1'b0;
            pass_active     <= 1'b1;
            raster_enable_r <= 1'b1;
          end
        end
        DRAW: begin
          if (!bus.raster_busy && bus.dc_all_complete) begin
            state       <= DRAIN;
            drain_count <= '0;
          end
        end
        DRAIN: begin
          // idle cycles absorb the comparator's registered write lag
          if (bus.raster_busy || !bus.dc_all_complete) begin
            state <= DRAW;
          end else if (drain_next == DRAIN_W'(DRAIN_CYCLES)) begin
            state           <= SWAP_WAIT;
            pass_active     <= 1'b0;
            raster_enable_r <= 1'b0;
          end else begin
            drain_count <= drain_next;
          end
        end
        SWAP_WAIT: begin
          if (bus.vblank) begin
            buffer_select_r <= ~buffer_select_r;
            frame_done_r    <= 1'b1;
            pending         <= 1'b0;
            if (start_req) begin
              state        <= CLEAR;
              clear_active <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // draw phase hands the port straight to the comparator with no latency
  assign bus.buffer_write_enable = pass_active ? bus.dc_write_enable : clear_active;
  assign bus.buffer_address_x    = pass_active ? bus.dc_address_x    : scan_x;
  assign bus.buffer_address_y    = pass_active ? bus.dc_address_y    : scan_y;
  assign bus.buffer_write_data   = pass_active  ? bus.dc_write_data :
                                   clear_active ? CLEAR_PIXEL       : '0;

  assign bus.raster_enable = raster_enable_r;
  assign bus.buffer_select = buffer_select_r;
  assign bus.frame_done    = frame_done_r;
  assign bus.busy          = busy_r;
  assign bus.overlap_error = overlap_error_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized and directed stimulus for frame_sequencer against a frame-level reference model.
module tb_frame_sequencer;
  import common::*;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int unsigned DC = 2;
  localparam int M_IDLE  = 0;
  localparam int M_CLEAR = 1;
  localparam int M_DRAW  = 2;
  localparam int M_SWAP  = 3;

  logic clock = 1'b0;
  logic reset;

  frame_sequencer_if bus ();

  frame_sequencer #(
    .H_RES        (H),
    .V_RES        (V),
    .CLEAR_PIXEL  (pixel_t'(0)),
    .DRAIN_CYCLES (DC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned done_seen = 0;
  int unsigned wr_seen = 0;
  int unsigned ren_seen = 0;

  // reference: one mode per phase, draw+drain merged into a clean-cycle run length
  int m_mode;
  int m_idx;
  int m_clean;
  bit m_pend, m_sel, m_done, m_ovl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_idx = 0; m_clean = 0;
    m_pend = 0; m_sel = 0; m_done = 0; m_ovl = 0;
  endtask

  task automatic model_step();
    bit fs;
    fs = bus.frame_start;
    if (reset) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (bus.dc_write_enable && m_mode != M_DRAW) m_ovl = 1;
    case (m_mode)
      M_IDLE: if (fs || m_pend) begin m_mode = M_CLEAR; m_idx = 0; m_pend = 0; end
      M_CLEAR: begin
        if (fs) m_pend = 1;
        if (m_idx == int'(H * V) - 1) begin m_mode = M_DRAW; m_clean = 0; end
        else m_idx++;
      end
      M_DRAW: begin
        if (fs) m_pend = 1;
        if (!bus.raster_busy && bus.dc_all_complete) m_clean++;
        else m_clean = 0;
        if (m_clean == int'(DC) + 1) m_mode = M_SWAP;
      end
      default: begin
        if (bus.vblank) begin
          m_sel  = ~m_sel;
          m_done = 1;
          m_mode = (m_pend || fs) ? M_CLEAR : M_IDLE;
          m_idx  = 0;
          m_pend = 0;
        end else if (fs) begin
          m_pend = 1;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    logic               e_we;
    logic [COORD_W-1:0] e_x, e_y;
    pixel_t             e_d;
    e_we = 1'b0; e_x = '0; e_y = '0; e_d = '0;
    if (m_mode == M_CLEAR) begin
      e_we = 1'b1;
      e_x  = COORD_W'(m_idx % int'(H));
      e_y  = COORD_W'(m_idx / int'(H));
    end else if (m_mode == M_DRAW) begin
      e_we = bus.dc_write_enable;
      e_x  = bus.dc_address_x;
      e_y  = bus.dc_address_y;
      e_d  = bus.dc_write_data;
    end
    check("raster_enable", 64'(bus.raster_enable), 64'(m_mode == M_DRAW));
    check("busy", 64'(bus.busy), 64'(m_mode != M_IDLE));
    check("frame_done", 64'(bus.frame_done), 64'(m_done));
    check("buffer_select", 64'(bus.buffer_select), 64'(m_sel));
    check("overlap_error", 64'(bus.overlap_error), 64'(m_ovl));
    check("write_enable", 64'(bus.buffer_write_enable), 64'(e_we));
    check("address_x", 64'(bus.buffer_address_x), 64'(e_x));
    check("address_y", 64'(bus.buffer_address_y), 64'(e_y));
    check("write_data", 64'(bus.buffer_write_data), 64'(e_d));
    if (bus.frame_done === 1'b1) done_seen++;
    if (bus.buffer_write_enable === 1'b1) wr_seen++;
    if (bus.raster_enable === 1'b1) ren_seen++;
  endtask

  task automatic cycle();
    @(negedge clock);
    compare_all();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drive(input bit fs, input bit vb, input bit rb, input bit dcc);
    bus.frame_start     = fs;
    bus.vblank          = vb;
    bus.raster_busy     = rb;
    bus.dc_all_complete = dcc;
  endtask

  task automatic dc_write(input bit we, input int x, input int y, input pixel_t d);
    bus.dc_write_enable = we;
    bus.dc_address_x    = COORD_W'(x);
    bus.dc_address_y    = COORD_W'(y);
    bus.dc_write_data   = d;
  endtask

  initial begin
    pixel_t px;
    reset = 1'b1;
    drive(0, 0, 1, 0);
    dc_write(0, 0, 0, '0);
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    cycle();
    reset = 1'b0;

    // frame 1: clear sweep, one comparator write, drain, late vblank swap
    drive(1, 0, 1, 0);
    cycle();
    drive(0, 0, 1, 0);
    wr_seen = 0;
    run(12);
    check("clear_write_count", 64'(wr_seen), 64'd12);
    px.depth = 8'd5;
    px.color = 24'h00a5c3;
    dc_write(1, 2, 1, px);
    cycle();
    dc_write(0, 0, 0, '0);
    drive(0, 0, 0, 1);
    ren_seen = 0;
    done_seen = 0;
    run(10);
    check("drain_raster_cycles", 64'(ren_seen), 64'd3);
    check("no_swap_before_vblank", 64'(done_seen), 64'd0);
    drive(0, 1, 0, 1);
    run(3);
    check("frame1_done_pulses", 64'(done_seen), 64'd1);
    check("frame1_select", 64'(bus.buffer_select), 64'd1);
    check("frame1_idle", 64'(bus.busy), 64'd0);

    // frame 2: busy glitch during drain restarts the drain count
    drive(1, 1, 1, 0);
    cycle();
    drive(0, 1, 1, 0);
    run(12);
    drive(0, 1, 0, 1);
    run(2);
    drive(0, 1, 1, 1);
    cycle();
    drive(0, 1, 0, 1);
    done_seen = 0;
    run(2);
    check("glitch_no_swap", 64'(done_seen), 64'd0);
    run(3);
    check("glitch_done_pulses", 64'(done_seen), 64'd1);
    check("glitch_select", 64'(bus.buffer_select), 64'd0);

    // frame 3: two merged start requests chain straight into the next clear
    drive(1, 0, 1, 0);
    cycle();
    drive(0, 0, 1, 0);
    run(12);
    drive(1, 0, 1, 0); cycle();
    drive(0, 0, 1, 0); cycle();
    drive(1, 0, 1, 0); cycle();
    drive(0, 0, 0, 1);
    run(5);
    drive(0, 1, 0, 1);
    done_seen = 0;
    run(2);
    check("chain_done_pulses", 64'(done_seen), 64'd1);
    check("chain_busy", 64'(bus.busy), 64'd1);
    check("chain_clearing", 64'(bus.buffer_write_enable), 64'd1);
    check("chain_select", 64'(bus.buffer_select), 64'd1);

    // comparator write inside clear, then reset mid-clear
    drive(0, 0, 1, 0);
    px.depth = 8'd7;
    dc_write(1, 0, 0, px);
    cycle();
    dc_write(0, 0, 0, '0);
    cycle();
    check("overlap_sticky", 64'(bus.overlap_error), 64'd1);
    run(3);
    check("overlap_held", 64'(bus.overlap_error), 64'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_select", 64'(bus.buffer_select), 64'd0);
    check("rst_overlap", 64'(bus.overlap_error), 64'd0);
    check("rst_write_enable", 64'(bus.buffer_write_enable), 64'd0);
    check("rst_raster", 64'(bus.raster_enable), 64'd0);
    run(2);

    // random traffic against the model
    done_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 16) == 0) bus.vblank = ~bus.vblank;
      bus.frame_start     = (($urandom % 24) == 0);
      bus.raster_busy     = (($urandom % 4) == 0);
      bus.dc_all_complete = (($urandom % 5) != 0);
      px = pixel_t'($urandom);
      dc_write((($urandom % 3) == 0), int'($urandom % 1024), int'($urandom % 1024), px);
      reset = (($urandom % 700) == 0);
      cycle();
    end
    reset = 1'b0;
    check("random_frames_completed", 64'(done_seen != 0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
